// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: four-digit switch code lock with entry timeout, timed unlock,
// and an alarm lockout after MAX_FAIL consecutive mismatches.
module code_lock_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int UNLOCK_CYCLES  = 500,
    parameter int LOCKOUT_CYCLES = 2000,
    parameter int MAX_FAIL       = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  SW_CHANGE_FLAG,
    input  logic [3:0]  WHICH_SW_CHANGE,
    input  logic [15:0] PRESET_CODE,
    output logic [15:0] ENTRY,
    output logic [2:0]  DIGIT_CNT,
    output logic [2:0]  STATE,
    output logic        UNLOCK,
    output logic        ERR,
    output logic        ALARM,
    output logic [1:0]  FAIL_CNT
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] UN_LAST = 16'(UNLOCK_CYCLES - 1);
    localparam logic [15:0] LO_LAST = 16'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]  FAIL_LIM = 2'(MAX_FAIL);

    state_t      state_q, state_d;
    logic [15:0] entry_q, entry_d, timer_q, timer_d, shifted;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  fail_q, fail_d, fail_inc;
    logic        unlock_q, err_q, alarm_q, digit;

    assign digit    = (SW_CHANGE_FLAG == 2'b11) && (WHICH_SW_CHANGE <= 4'd9);
    assign shifted  = {entry_q[11:0], WHICH_SW_CHANGE};
    assign fail_inc = fail_q + 2'd1;

    // timer_q is shared: inactivity count in ENTRY, hold count in OPEN/LOCKOUT
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (digit) begin
                    entry_d = shifted;
                    cnt_d   = 3'd1;
                    timer_d = 16'd0;
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (digit) begin
                    entry_d = shifted;
                    cnt_d   = cnt_q + 3'd1;
                    timer_d = 16'd0;
                    state_d = (cnt_q == 3'd3) ? S_CHECK : S_ENTRY;
                end else if (timer_q == TO_LAST) begin
                    entry_d = 16'hFFFF;
                    cnt_d   = 3'd0;
                    timer_d = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_CHECK: begin
                timer_d = 16'd0;
                if (entry_q == PRESET_CODE) begin
                    fail_d  = 2'd0;
                    state_d = S_OPEN;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == FAIL_LIM) ? S_LOCKOUT : S_FAIL;
                end
            end
            S_OPEN: begin
                if (timer_q == UN_LAST) begin
                    entry_d = 16'hFFFF;
                    cnt_d   = 3'd0;
                    timer_d = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_FAIL: begin
                entry_d = 16'hFFFF;
                cnt_d   = 3'd0;
                state_d = S_IDLE;
            end
            S_LOCKOUT: begin
                if (timer_q == LO_LAST) begin
                    entry_d = 16'hFFFF;
                    cnt_d   = 3'd0;
                    fail_d  = 2'd0;
                    timer_d = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                entry_d = 16'hFFFF;
                cnt_d   = 3'd0;
                timer_d = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            entry_q  <= 16'hFFFF;
            cnt_q    <= 3'd0;
            fail_q   <= 2'd0;
            timer_q  <= 16'd0;
            unlock_q <= 1'b0;
            err_q    <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            unlock_q <= (state_d == S_OPEN);
            err_q    <= (state_d == S_FAIL);
            alarm_q  <= (state_d == S_LOCKOUT);
        end
    end

    assign STATE     = state_q;
    assign ENTRY     = entry_q;
    assign DIGIT_CNT = cnt_q;
    assign FAIL_CNT  = fail_q;
    assign UNLOCK    = unlock_q;
    assign ERR       = err_q;
    assign ALARM     = alarm_q;
endmodule
